fm_acblock: RTL and testbench

FM_ACBLOCK -- requirements
Module: fm_acblock

---
 rtl/fm_pkg.sv | 26 ++
 rtl/fm_acblock_if.sv | 42 ++++
 rtl/fm_ram.sv | 30 +++
 rtl/fm_acblock.sv | 130 +++++++++++++
 tb/tb_fm_acblock.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fm_pkg.sv
// Shared definitions for the fast-memory AC block: defaults, sweep FSM states,
// AC index type and the odd-parity helper.
package fm_pkg;

    localparam int FM_WIDTH         = 36;
    localparam int FM_NBLK          = 8;
    localparam int FM_WORDS_PER_BLK = 16;
    localparam int FM_IDX_W         = 7;

    typedef logic [FM_IDX_W-1:0] fm_idx_t;

    typedef enum logic [1:0] {
        FM_IDLE  = 2'd0,
        FM_SWEEP = 2'd1,
        FM_DONE  = 2'd2
    } fm_state_e;

    localparam fm_idx_t    FM_LAST_IDX = 7'd127;
    localparam logic [7:0] FM_CNT_MAX  = 8'hff;

    // Zero-extending the argument leaves its parity unchanged, so any width up to 64 fits.
    function automatic logic fm_odd_par(input logic [63:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/fm_acblock_if.sv
// Bus between the EDP datapath and the fast-memory AC block.
interface fm_acblock_if
    import fm_pkg::*;
#(
    parameter int WIDTH = FM_WIDTH
) ();

    // No valid/ready pairs here: con_fm_write_l is a per-edge strobe that is always
    // accepted, reads are combinational from the address, and diag_done_h is a
    // one-cycle completion pulse with no back-pressure.
    logic [2:0]       apr_fm_block_h;
    logic [3:0]       apr_fm_adr_h;
    logic             con_fm_write_l;
    logic [WIDTH-1:0] ad_h;
    logic             diag_bad_par_h;
    logic             fm_par_chk_en_h;
    logic             diag_sweep_h;

    logic [WIDTH-1:0] fm_h;
    logic             edp_fm_parity_h;
    logic             fm_par_err_h;
    logic             diag_busy_h;
    logic             diag_done_h;
    logic [7:0]       diag_err_cnt_h;
    fm_idx_t          diag_first_err_adr_h;
    fm_state_e        fm_state;

    modport master (
        output apr_fm_block_h, apr_fm_adr_h, con_fm_write_l, ad_h,
               diag_bad_par_h, fm_par_chk_en_h, diag_sweep_h,
        input  fm_h, edp_fm_parity_h, fm_par_err_h, diag_busy_h, diag_done_h,
               diag_err_cnt_h, diag_first_err_adr_h, fm_state
    );

    modport slave (
        input  apr_fm_block_h, apr_fm_adr_h, con_fm_write_l, ad_h,
               diag_bad_par_h, fm_par_chk_en_h, diag_sweep_h,
        output fm_h, edp_fm_parity_h, fm_par_err_h, diag_busy_h, diag_done_h,
               diag_err_cnt_h, diag_first_err_adr_h, fm_state
    );

endinterface

// File: rtl/fm_ram.sv
// AC word array: one synchronous write port, two combinational read ports.
// Words are {data, parity}; contents are deliberately not reset.
module fm_ram
    import fm_pkg::*;
#(
    parameter int WIDTH = FM_WIDTH,
    parameter int DEPTH = FM_NBLK * FM_WORDS_PER_BLK
) (
    input  logic           clk,
    input  logic           we,
    input  fm_idx_t        wr_idx,
    input  logic [WIDTH:0] wr_word,
    input  fm_idx_t        rd_a_idx,
    output logic [WIDTH:0] rd_a_word,
    input  fm_idx_t        rd_b_idx,
    output logic [WIDTH:0] rd_b_word
);

    logic [WIDTH:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_word;
        end
    end

    assign rd_a_word = mem[rd_a_idx];
    assign rd_b_word = mem[rd_b_idx];

endmodule

// File: rtl/fm_acblock.sv
// Fast-memory AC block: staged writes with read bypass, read parity check and
// a background full-array parity sweep.
module fm_acblock
    import fm_pkg::*;
#(
    parameter int WIDTH = FM_WIDTH,
    parameter int NBLK  = FM_NBLK
) (
    input  logic        clk_edp_h,
    input  logic        mr_reset_l,
    fm_acblock_if.slave bus
);

    fm_idx_t        rd_idx;
    fm_idx_t        stage_idx;
    fm_idx_t        sweep_idx;
    fm_idx_t        first_err;
    logic           stage_valid;
    logic [WIDTH:0] stage_word;
    logic [WIDTH:0] ram_a_word;
    logic [WIDTH:0] ram_b_word;
    logic [WIDTH:0] rd_word;
    logic [WIDTH:0] sw_word;
    fm_state_e      state;
    logic [7:0]     err_cnt;
    logic           par_err;
    logic           sweep_start;
    logic           sweep_bad;
    logic           read_bad;

    assign rd_idx = {bus.apr_fm_block_h, bus.apr_fm_adr_h};

    // Write stage: loaded on a write edge, committed to the array on the next edge.
    always_ff @(posedge clk_edp_h or negedge mr_reset_l) begin
        if (!mr_reset_l) begin
            stage_valid <= 1'b0;
        end else begin
            stage_valid <= !bus.con_fm_write_l;
        end
    end

    always_ff @(posedge clk_edp_h) begin
        if (!bus.con_fm_write_l) begin
            stage_idx  <= rd_idx;
            stage_word <= {bus.ad_h, fm_odd_par(64'(bus.ad_h)) ^ bus.diag_bad_par_h};
        end
    end

    fm_ram #(
        .WIDTH (WIDTH),
        .DEPTH (NBLK * FM_WORDS_PER_BLK)
    ) u_ram (
        .clk       (clk_edp_h),
        .we        (stage_valid),
        .wr_idx    (stage_idx),
        .wr_word   (stage_word),
        .rd_a_idx  (rd_idx),
        .rd_a_word (ram_a_word),
        .rd_b_idx  (sweep_idx),
        .rd_b_word (ram_b_word)
    );

    // Both read ports see a pending stage so a word is never observed stale.
    assign rd_word = (stage_valid && stage_idx == rd_idx)    ? stage_word : ram_a_word;
    assign sw_word = (stage_valid && stage_idx == sweep_idx) ? stage_word : ram_b_word;

    assign bus.fm_h            = rd_word[WIDTH:1];
    assign bus.edp_fm_parity_h = rd_word[0];

    assign read_bad    = bus.fm_par_chk_en_h && !(^rd_word);
    assign sweep_bad   = !(^sw_word);
    assign sweep_start = (state == FM_IDLE) && bus.diag_sweep_h;

    always_ff @(posedge clk_edp_h or negedge mr_reset_l) begin
        if (!mr_reset_l) begin
            state     <= FM_IDLE;
            sweep_idx <= '0;
            err_cnt   <= '0;
            first_err <= '0;
            par_err   <= 1'b0;
        end else begin
            if (sweep_start) begin
                par_err <= 1'b0;
            end else if (read_bad) begin
                par_err <= 1'b1;
            end

            case (state)
                FM_IDLE: begin
                    if (bus.diag_sweep_h) begin
                        state     <= FM_SWEEP;
                        sweep_idx <= '0;
                        err_cnt   <= '0;
                        first_err <= '0;
                    end
                end
                FM_SWEEP: begin
                    if (sweep_bad) begin
                        if (err_cnt != FM_CNT_MAX) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                        // The count was cleared at start, so zero marks the first failure.
                        if (err_cnt == 8'd0) begin
                            first_err <= sweep_idx;
                        end
                    end
                    if (sweep_idx == FM_LAST_IDX) begin
                        state <= FM_DONE;
                    end else begin
                        sweep_idx <= sweep_idx + 7'd1;
                    end
                end
                FM_DONE: begin
                    state <= FM_IDLE;
                end
                default: begin
                    state <= FM_IDLE;
                end
            endcase
        end
    end

    assign bus.fm_par_err_h         = par_err;
    assign bus.diag_busy_h          = (state != FM_IDLE);
    assign bus.diag_done_h          = (state == FM_DONE);
    assign bus.diag_err_cnt_h       = err_cnt;
    assign bus.diag_first_err_adr_h = first_err;
    assign bus.fm_state             = state;

endmodule

// File: tb/tb_fm_acblock.sv
// Self-checking bench for fm_acblock: drivers push expectations from a word-level
// model; a negedge monitor pops and compares reads and sweep completions.
module tb_fm_acblock;
    import fm_pkg::*;

    localparam int W  = 36;
    localparam int NW = 128;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fm_acblock_if #(.WIDTH(W)) bus ();

    fm_acblock #(.WIDTH(W), .NBLK(8)) dut (
        .clk_edp_h  (clk),
        .mr_reset_l (rst_n),
        .bus        (bus)
    );

    // Reference model: plain word contents plus whether the stored parity is corrupt.
    logic [W-1:0] m_data [NW];
    bit           m_bad  [NW];
    bit           m_err;

    logic [W+1:0] exp_q[$];    // {err, parity, data}
    logic [14:0]  sweep_q[$];  // {count, first index}

    int   n_checks  = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   start_cyc = 0;
    logic rd_en     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic exp_par(input logic [W-1:0] d, input bit bad);
        return (($countones(d) % 2) == 0) ^ bad;
    endfunction

    function automatic logic [W-1:0] rand_word();
        return W'({$urandom(), $urandom()});
    endfunction

    // Monitor
    always @(negedge clk) begin : monitor
        logic [W+1:0] e;
        logic [14:0]  s;
        if (rd_en) begin
            check("rd_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rd_data", bus.fm_h, e[W-1:0]);
                check("rd_par", bus.edp_fm_parity_h, e[W]);
                check("rd_err", bus.fm_par_err_h, e[W+1]);
            end
        end
        if (bus.diag_done_h) begin
            check("done_expected", sweep_q.size() > 0, 1);
            if (sweep_q.size() > 0) begin
                s = sweep_q.pop_front();
                check("sweep_cnt", bus.diag_err_cnt_h, s[14:7]);
                check("sweep_first", bus.diag_first_err_adr_h, s[6:0]);
                // The DONE cycle is the 129th cycle counted from the start edge.
                check("sweep_latency", cyc - start_cyc + 1, 129);
                check("sweep_busy", bus.diag_busy_h, 1);
            end
        end
    end

    // Drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_adr(input int idx);
        bus.apr_fm_block_h = 3'(idx >> 4);
        bus.apr_fm_adr_h   = 4'(idx);
    endtask

    task automatic wr(input int idx, input logic [W-1:0] d, input bit bad);
        set_adr(idx);
        bus.ad_h           = d;
        bus.diag_bad_par_h = bad;
        bus.con_fm_write_l = 1'b0;
        m_data[idx] = d;
        m_bad[idx]  = bad;
        tick();
        bus.con_fm_write_l = 1'b1;
        bus.diag_bad_par_h = 1'b0;
    endtask

    task automatic rd_push(input int idx, input bit chk, input logic [W+1:0] e);
        set_adr(idx);
        bus.fm_par_chk_en_h = chk;
        rd_en = 1'b1;
        exp_q.push_back(e);
        tick();
        rd_en = 1'b0;
        bus.fm_par_chk_en_h = 1'b0;
        if (chk && m_bad[idx]) m_err = 1'b1;
    endtask

    task automatic rd(input int idx, input bit chk);
        rd_push(idx, chk, {m_err, exp_par(m_data[idx], m_bad[idx]), m_data[idx]});
    endtask

    task automatic sweep_begin();
        bus.diag_sweep_h = 1'b1;
        tick();
        bus.diag_sweep_h = 1'b0;
        start_cyc = cyc;
        m_err = 1'b0;
    endtask

    task automatic sweep_expect();
        int      cnt;
        fm_idx_t first;
        cnt   = 0;
        first = '0;
        for (int i = 0; i < NW; i++) begin
            if (m_bad[i]) begin
                if (cnt == 0) first = 7'(i);
                if (cnt < 255) cnt++;
            end
        end
        sweep_q.push_back({8'(cnt), first});
    endtask

    task automatic sweep_wait();
        int n;
        n = 0;
        while (sweep_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        check("sweep_timeout", sweep_q.size(), 0);
        tick();
        check("busy_after_sweep", bus.diag_busy_h, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        sweep_q.delete();
        m_err = 1'b0;
        #2;
        check("rst_state", bus.fm_state, FM_IDLE);
        check("rst_busy", bus.diag_busy_h, 0);
        check("rst_done", bus.diag_done_h, 0);
        check("rst_cnt", bus.diag_err_cnt_h, 0);
        check("rst_first", bus.diag_first_err_adr_h, 0);
        check("rst_par_err", bus.fm_par_err_h, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int op;
        int idx;
        bus.apr_fm_block_h  = '0;
        bus.apr_fm_adr_h    = '0;
        bus.con_fm_write_l  = 1'b1;
        bus.ad_h            = '0;
        bus.diag_bad_par_h  = 1'b0;
        bus.fm_par_chk_en_h = 1'b0;
        bus.diag_sweep_h    = 1'b0;
        m_err = 1'b0;
        for (int i = 0; i < NW; i++) begin
            m_data[i] = '0;
            m_bad[i]  = 1'b0;
        end

        #1;
        do_reset();

        // Block 2 AC 5 round trip, with checking enabled.
        wr(37, 36'o123456701234, 1'b0);
        tick();
        rd_push(37, 1'b1, {1'b0, 1'b0, 36'o123456701234});
        rd_push(37, 1'b0, {1'b0, 1'b0, 36'o123456701234});

        // Read the following cycle, served from the write stage.
        wr(3, 36'o777, 1'b0);
        rd_push(3, 1'b1, {1'b0, 1'b0, 36'o777});
        rd(3, 1'b0);

        // Back-to-back writes.
        wr(64, 36'd1, 1'b0);
        wr(65, 36'd2, 1'b0);
        wr(66, 36'd3, 1'b0);
        rd_push(66, 1'b0, {1'b0, 1'b1, 36'd3});
        rd_push(64, 1'b0, {1'b0, 1'b0, 36'd1});
        rd_push(65, 1'b0, {1'b0, 1'b0, 36'd2});

        // Fault-injected write to block 1 AC 7, then checked read.
        wr(23, rand_word(), 1'b1);
        rd(23, 1'b1);
        rd(23, 1'b0);
        repeat (3) tick();
        rd(23, 1'b0);
        check("err_held", bus.fm_par_err_h, 1);

        // Fill the array, corrupt two words, sweep.
        for (int i = 0; i < NW; i++) wr(i, rand_word(), 1'b0);
        wr(9, rand_word(), 1'b1);
        wr(100, rand_word(), 1'b1);
        tick();
        sweep_begin();
        sweep_expect();
        sweep_wait();
        check("sweep1_cnt_const", bus.diag_err_cnt_h, 2);
        check("sweep1_first_const", bus.diag_first_err_adr_h, 9);
        rd(5, 1'b0);

        // Reset while the sweep is at index 40, then a clean sweep.
        sweep_begin();
        repeat (40) tick();
        do_reset();
        repeat (140) tick();
        sweep_begin();
        sweep_expect();
        sweep_wait();

        // Writes ahead of the sweep pointer are seen; a second start request is ignored.
        sweep_begin();
        repeat (20) tick();
        wr(110, rand_word(), 1'b1);
        wr(100, rand_word(), 1'b0);
        sweep_expect();
        bus.diag_sweep_h = 1'b1;
        tick();
        bus.diag_sweep_h = 1'b0;
        sweep_wait();

        // Random traffic followed by a sweep over the result.
        repeat (400) begin
            op  = $urandom_range(0, 3);
            idx = $urandom_range(0, NW - 1);
            if (op == 0) wr(idx, rand_word(), $urandom_range(0, 7) == 0);
            else         rd(idx, 1'($urandom_range(0, 1)));
        end
        sweep_begin();
        sweep_expect();
        sweep_wait();

        repeat (2) tick();
        check("rd_q_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
